// File: rtl/gas_status_uart_tx.sv
// UART 8N1 status reporter for gas_fsm: sends a 3-byte frame {A5, {seq,status}, xor}
// on status change, on heartbeat expiry and once after reset.
module gas_status_uart_tx #(
  parameter int unsigned CLKS_PER_BIT     = 868,
  parameter int unsigned HEARTBEAT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       V,
  input  logic       B,
  input  logic       S,
  input  logic       L,
  input  logic       A,
  input  logic       U,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HB_LAST   = 32'(HEARTBEAT_CYCLES - 1);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      r_state;
  logic [5:0]  r_st_q;
  logic [5:0]  r_last;
  logic        r_pending;
  logic [31:0] r_hb;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [1:0]  r_byte;
  logic [7:0]  r_shift;
  logic [7:0]  r_b1;
  logic [7:0]  r_b2;
  logic        r_tx;
  logic        r_busy;
  logic [7:0]  r_frame_cnt;

  logic        w_start;
  logic        w_baud_end;
  logic [7:0]  w_b1;

  assign w_start    = (r_state == IDLE) && r_pending;
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_b1       = {r_frame_cnt[1:0], r_st_q};

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;

  // Inputs come from gas_fsm in the same clock domain: one register stage only.
  always_ff @(posedge clk) begin
    r_st_q <= {V, B, S, L, A, U};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= '0;
      r_pending   <= 1'b1;
      r_hb        <= '0;
      r_baud      <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_shift     <= '0;
      r_b1        <= '0;
      r_b2        <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_start)
        r_hb <= '0;
      else if (r_hb != HB_LAST)
        r_hb <= r_hb + 32'd1;

      // Sticky until a frame starts, so a reverted change still yields a frame.
      if (w_start)
        r_pending <= 1'b0;
      else if ((r_st_q != r_last) || (r_hb == HB_LAST))
        r_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_start) begin
            r_last  <= r_st_q;
            r_b1    <= w_b1;
            r_b2    <= SYNC_BYTE ^ w_b1;
            r_shift <= SYNC_BYTE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_busy  <= 1'b1;
            r_tx    <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_byte == 2'd2) begin
              r_byte      <= '0;
              r_busy      <= 1'b0;
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_state     <= IDLE;
            end else begin
              r_byte  <= r_byte + 2'd1;
              r_shift <= (r_byte == 2'd0) ? r_b1 : r_b2;
              r_tx    <= 1'b0;
              r_state <= START;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gas_status_uart_tx.sv
// Bench for gas_status_uart_tx: records tx per cycle, decodes frames as a UART receiver
// would, and checks them against payloads derived from the driven status history.
module tb_gas_status_uart_tx;

  localparam int CPB = 4;
  localparam int HB  = 2000;
  localparam int FL  = 30 * CPB;
  localparam int NH  = 1 << 17;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] st;
  logic       tx;
  logic       busy;
  logic [7:0] frame_cnt;

  logic       txh   [0:NH-1];
  logic       busyh [0:NH-1];
  logic [5:0] sth   [0:NH-1];

  int         cyc;
  int         n_cmp;
  int         n_bad;
  logic [7:0] ex_cnt;

  always #5 clk = ~clk;

  gas_status_uart_tx #(
    .CLKS_PER_BIT    (CPB),
    .HEARTBEAT_CYCLES(HB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .V        (st[5]),
    .B        (st[4]),
    .S        (st[3]),
    .L        (st[2]),
    .A        (st[1]),
    .U        (st[0]),
    .tx       (tx),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_up();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // sth[c] holds the status driven between edge c and edge c+1.
  task automatic tick();
    if (cyc >= NH - 2) begin
      $display("FAIL cycle_budget: observed %0d expected below %0d", cyc, NH - 2);
      $fatal(1, "history exhausted");
    end
    sth[cyc] = st;
    @(posedge clk);
    cyc++;
    #1;
    txh[cyc]   = tx;
    busyh[cyc] = busy;
  endtask

  task automatic wait_start(input int budget, output int s);
    s = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tx === 1'b0 && txh[cyc-1] === 1'b1) begin
        s = cyc;
        break;
      end
    end
    chk("start_seen", 32'(s >= 0), 32'd1);
    if (s < 0) finish_up();
  endtask

  task automatic get_frame(input int s);
    logic [7:0] b [3];
    logic [7:0] exp_b1;
    int base;
    while (cyc < s + FL) tick();
    for (int k = 0; k < 3; k++) begin
      base = s + 10 * CPB * k;
      for (int i = 0; i < 8; i++) b[k][i] = txh[base + CPB * (1 + i) + CPB / 2];
      chk("start_bit", 32'(txh[base + CPB / 2]), 32'd0);
      chk("stop_bit", 32'(txh[base + 9 * CPB + CPB / 2]), 32'd1);
    end
    exp_b1 = {ex_cnt[1:0], sth[s-2]};
    chk("b0", 32'(b[0]), 32'h0A5);
    chk("b1", 32'(b[1]), 32'(exp_b1));
    chk("b2", 32'(b[2]), 32'(8'hA5 ^ exp_b1));
    ex_cnt = ex_cnt + 8'd1;
    chk("frame_cnt", 32'(frame_cnt), 32'(ex_cnt));
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    int s1, s2, s3, s4, s5, s6, s, sn, rel, c, bc;
    logic [5:0] pay;
    logic [5:0] r;
    cyc = 0; n_cmp = 0; n_bad = 0; ex_cnt = '0;
    txh[0] = 1'b1; busyh[0] = 1'b0;
    rst = 1'b1;
    st  = '0;

    // 1: reset and boot frame
    repeat (3) tick();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    rel = cyc;
    wait_start(10, s1);
    chk("boot_latency", 32'((s1 - rel) <= 2), 32'd1);
    get_frame(s1);
    bc = 0;
    for (int i = s1 - 1; i <= s1 + FL; i++) bc += int'(busyh[i]);
    chk("busy_len", 32'(bc), 32'(FL));

    // 2: single change, latency from input to start bit
    st = 6'b000010;
    c = cyc;
    wait_start(20, s2);
    chk("chg_latency", 32'(s2), 32'(c + 3));

    // 3: two changes mid-frame coalesce into one back-to-back frame
    while (cyc < s2 + 30) tick();
    st = st | 6'b100000;
    while (cyc < s2 + 50) tick();
    st = st | 6'b001000;
    get_frame(s2);
    wait_start(4, s3);
    chk("b2b_gap", 32'(s3), 32'(s2 + FL + 1));
    get_frame(s3);

    // 4: heartbeat with inputs held
    wait_start(HB + 100, s4);
    chk("hb_period", 32'(s4), 32'(s3 + HB + 1));
    get_frame(s4);

    // 5: reset in bit 5 of byte 1 of the next heartbeat frame
    wait_start(HB + 100, s5);
    chk("hb_period2", 32'(s5), 32'(s4 + HB + 1));
    while (cyc < s5 + 10 * CPB + 6 * CPB) tick();
    rst = 1'b1;
    st  = '0;
    tick();
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    ex_cnt = '0;
    tick();
    rst = 1'b0;
    rel = cyc;
    wait_start(10, s6);
    chk("reboot_latency", 32'((s6 - rel) <= 2), 32'd1);

    // 6: random changes with U toggled per frame, 256 frames back to back
    s = s6;
    for (int f = 0; f < 256; f++) begin
      if (f < 255) begin
        pay = sth[s-2];
        while (cyc < s + int'($urandom_range(2, 60))) tick();
        r  = 6'($urandom);
        st = {r[5:1], st[0]};
        while (cyc < s + int'($urandom_range(61, 100))) tick();
        r  = 6'($urandom);
        st = {r[5:1], ~pay[0]};
      end
      get_frame(s);
      if (f < 255) begin
        wait_start(4, sn);
        chk("rand_b2b", 32'(sn), 32'(s + FL + 1));
        s = sn;
      end
    end
    chk("cnt_wrap", 32'(frame_cnt), 32'd0);

    finish_up();
  end

endmodule
